// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencer.
//   state_t   : sequencer state encoding (3 bits, IDLE = 0)
//   CNT_W_DEF : default width of the cycle / retired-instruction counters
//   PC_SEQ/PC_BR : pc_sel encoding (sequential PC vs branch target)
package seq_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    localparam int unsigned CNT_W_DEF = 32;

    localparam logic PC_SEQ = 1'b0;
    localparam logic PC_BR  = 1'b1;

endpackage

// File: rtl/seq_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, clears the count
//   inc : increment request for this cycle
//   cnt : current count (W bits)
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle sequencer: steps each instruction through FETCH, DECODE,
// EXEC, optional MEM and WB, driving the datapath enables per state,
// owning the data-memory handshake and halt, and counting active cycles
// and retired instructions.
//   clk, rst           : clock and synchronous active-high reset
//   run                : start request, sampled only in IDLE
//   is_load, is_store,
//   is_halt, wren      : decoder outputs for the current instruction
//   br_taken           : ALU branch outcome, sampled in EXEC
//   dm_ack             : data memory completes the pending access
//   ir_we, pc_we,
//   pc_sel, rf_we      : datapath enables
//   dm_req, dm_we      : data-memory request / direction
//   halted             : core stopped by a halt instruction
//   cycle_cnt, instret : saturating bring-up counters
module seq_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             is_halt,
    input  logic             wren,
    input  logic             br_taken,
    input  logic             dm_ack,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             rf_we,
    output logic             dm_req,
    output logic             dm_we,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret
);

    state_t state_q;
    state_t state_d;
    logic   br_q;
    logic   br_d;
    logic   cyc_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            br_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            br_q    <= br_d;
        end
    end

    always_comb begin
        state_d = state_q;
        br_d    = br_q;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        pc_sel  = PC_SEQ;
        rf_we   = 1'b0;
        dm_req  = 1'b0;
        dm_we   = 1'b0;
        halted  = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = DECODE;
            end
            DECODE: begin
                ir_we   = 1'b1;
                // Halt takes priority over any memory op flagged alongside it.
                state_d = is_halt ? HALT : EXEC;
            end
            EXEC: begin
                br_d    = br_taken;
                state_d = (is_load || is_store) ? MEM : WB;
            end
            MEM: begin
                dm_req = 1'b1;
                dm_we  = is_store;
                if (dm_ack) begin
                    if (is_store) begin
                        // Stores have nothing to write back: retire here.
                        pc_we   = 1'b1;
                        pc_sel  = PC_SEQ;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                rf_we   = wren && !is_store;
                pc_we   = 1'b1;
                pc_sel  = br_q ? PC_BR : PC_SEQ;
                state_d = FETCH;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cyc_inc = (state_q != IDLE) && (state_q != HALT);

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .inc (cyc_inc),
        .cnt (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_instret (
        .clk (clk),
        .rst (rst),
        .inc (pc_we),
        .cnt (instret)
    );

endmodule

// File: tb/tb_seq_ctrl.sv
module tb_seq_ctrl;

    localparam int K_ALU   = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;
    localparam int K_HALT  = 3;

    typedef struct packed {
        logic        ir_we;
        logic        pc_we;
        logic        pc_sel;
        logic        rf_we;
        logic        dm_req;
        logic        dm_we;
        logic        halted;
        logic [31:0] cyc;
        logic [31:0] ret;
        logic [3:0]  cyc4;
        logic [3:0]  ret4;
    } snap_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    logic is_load = 1'b0, is_store = 1'b0, is_halt = 1'b0, wren = 1'b0;
    logic br_taken = 1'b0, dm_ack = 1'b0;

    logic ir_we, pc_we, pc_sel, rf_we, dm_req, dm_we, halted;
    logic [31:0] cycle_cnt, instret;
    logic ir_we4, pc_we4, pc_sel4, rf_we4, dm_req4, dm_we4, halted4;
    logic [3:0] cycle_cnt4, instret4;

    int n_cmp = 0;
    int n_fail = 0;
    longint cyc_m = 0;
    longint ret_m = 0;
    snap_t obs_q[$];
    snap_t exp_q[$];

    always #5 clk = ~clk;

    seq_ctrl dut (
        .clk(clk), .rst(rst), .run(run), .is_load(is_load), .is_store(is_store),
        .is_halt(is_halt), .wren(wren), .br_taken(br_taken), .dm_ack(dm_ack),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
        .dm_req(dm_req), .dm_we(dm_we), .halted(halted),
        .cycle_cnt(cycle_cnt), .instret(instret)
    );

    seq_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .run(run), .is_load(is_load), .is_store(is_store),
        .is_halt(is_halt), .wren(wren), .br_taken(br_taken), .dm_ack(dm_ack),
        .ir_we(ir_we4), .pc_we(pc_we4), .pc_sel(pc_sel4), .rf_we(rf_we4),
        .dm_req(dm_req4), .dm_we(dm_we4), .halted(halted4),
        .cycle_cnt(cycle_cnt4), .instret(instret4)
    );

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic sample(output snap_t s);
        #1;
        s = '{ir_we, pc_we, pc_sel, rf_we, dm_req, dm_we, halted,
              cycle_cnt, instret, cycle_cnt4, instret4};
    endtask

    function automatic snap_t idle_snap();
        snap_t e;
        e = '0;
        e.cyc  = cyc_m[31:0];
        e.ret  = ret_m[31:0];
        e.cyc4 = (cyc_m > 15) ? 4'd15 : cyc_m[3:0];
        e.ret4 = (ret_m > 15) ? 4'd15 : ret_m[3:0];
        return e;
    endfunction

    function automatic int instr_len(int kind, int n, int hcyc);
        if (kind == K_HALT)  return 2 + hcyc;
        if (kind == K_ALU)   return 4;
        if (kind == K_LOAD)  return 5 + n;
        return 4 + n;
    endfunction

    // Reference: per-cycle expectations derived from the instruction's
    // cycle budget (FETCH, DECODE, EXEC, n+1 MEM cycles, WB).
    function automatic void model_instr(int kind, bit wr, bit br, int n, int rst_at, int hcyc);
        int len;
        snap_t e;
        len = instr_len(kind, n, hcyc);
        for (int c = 0; c < len; c++) begin
            e = idle_snap();
            if (kind == K_HALT && c >= 2) begin
                e.halted = 1'b1;
            end else if (c == 1) begin
                e.ir_we = 1'b1;
            end else if ((kind == K_LOAD || kind == K_STORE) && c >= 3 && c <= 3 + n) begin
                e.dm_req = 1'b1;
                e.dm_we  = (kind == K_STORE);
                e.pc_we  = (kind == K_STORE) && (c == 3 + n);
            end else if (c == len - 1 && kind != K_STORE && kind != K_HALT) begin
                e.rf_we  = wr;
                e.pc_we  = 1'b1;
                e.pc_sel = br;
            end
            exp_q.push_back(e);
            if (!e.halted) cyc_m++;
            if (e.pc_we) ret_m++;
            if (c == rst_at) begin
                cyc_m = 0;
                ret_m = 0;
                break;
            end
        end
    endfunction

    task automatic exec_instr(int kind, bit wr, bit br, int n, int rst_at, int hcyc);
        int len;
        snap_t s;
        bit in_mem;
        len = instr_len(kind, n, hcyc);
        for (int c = 0; c < len; c++) begin
            next_cycle();
            in_mem   = (kind == K_LOAD || kind == K_STORE) && c >= 3 && c <= 3 + n;
            rst      = (c == rst_at);
            run      = 1'($urandom);
            is_load  = (kind == K_LOAD) || (kind == K_HALT);
            is_store = (kind == K_STORE);
            is_halt  = (kind == K_HALT);
            wren     = wr;
            br_taken = (c == 2) ? br : 1'($urandom);
            dm_ack   = in_mem ? (c == 3 + n) : 1'($urandom);
            sample(s);
            obs_q.push_back(s);
            if (c == rst_at) break;
        end
    endtask

    task automatic start_core();
        snap_t s;
        next_cycle();
        rst = 1'b0; run = 1'b1; is_load = 1'b0; is_store = 1'b0; is_halt = 1'b0;
        wren = 1'b0; br_taken = 1'b0; dm_ack = 1'b0;
        sample(s);
    endtask

    task automatic reset_core();
        snap_t s;
        next_cycle();
        rst = 1'b1; run = 1'b0; dm_ack = 1'b0;
        sample(s);
        cyc_m = 0;
        ret_m = 0;
    endtask

    task automatic test_reset();
        snap_t s;
        reset_core();
        next_cycle();
        rst = 1'b0; run = 1'b0;
        sample(s);
        n_cmp++;
        if (s !== snap_t'('0)) begin
            n_fail++;
            $display("FAIL reset got=%h exp=%h", s, snap_t'('0));
        end
    endtask

    task automatic test_add();
        snap_t s;
        next_cycle();
        rst = 1'b0; run = 1'b1; is_load = 1'b0; is_store = 1'b0; is_halt = 1'b0;
        wren = 1'b1; dm_ack = 1'b1;
        sample(s);
        n_cmp++;
        if (s !== idle_snap()) begin
            n_fail++;
            $display("FAIL add_idle got=%h exp=%h", s, idle_snap());
        end
        obs_q.delete(); exp_q.delete();
        model_instr(K_ALU, 1'b1, 1'b0, 0, -1, 0);
        exec_instr(K_ALU, 1'b1, 1'b0, 0, -1, 0);
        foreach (obs_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL add c%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (cyc_m != 4 || ret_m != 1) begin
            n_fail++;
            $display("FAIL add_counts model cyc=%0d ret=%0d exp 4/1", cyc_m, ret_m);
        end
    endtask

    task automatic test_branch();
        obs_q.delete(); exp_q.delete();
        model_instr(K_ALU, 1'b0, 1'b1, 0, -1, 0);
        exec_instr(K_ALU, 1'b0, 1'b1, 0, -1, 0);
        model_instr(K_ALU, 1'b1, 1'b0, 0, -1, 0);
        exec_instr(K_ALU, 1'b1, 1'b0, 0, -1, 0);
        foreach (obs_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL branch c%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_load();
        obs_q.delete(); exp_q.delete();
        model_instr(K_LOAD, 1'b1, 1'b0, 3, -1, 0);
        exec_instr(K_LOAD, 1'b1, 1'b0, 3, -1, 0);
        n_cmp++;
        if (obs_q.size() != 8) begin
            n_fail++;
            $display("FAIL load_len got=%0d exp=8", obs_q.size());
        end
        foreach (obs_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL load c%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_store();
        obs_q.delete(); exp_q.delete();
        model_instr(K_STORE, 1'b1, 1'b0, 0, -1, 0);
        exec_instr(K_STORE, 1'b1, 1'b0, 0, -1, 0);
        // The following ALU op proves the store went straight back to FETCH.
        model_instr(K_ALU, 1'b0, 1'b0, 0, -1, 0);
        exec_instr(K_ALU, 1'b0, 1'b0, 0, -1, 0);
        foreach (obs_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL store c%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int kind, n;
        bit wr, br;
        obs_q.delete(); exp_q.delete();
        for (int k = 0; k < 30; k++) begin
            kind = int'($urandom_range(0, 2));
            wr   = 1'($urandom);
            br   = 1'($urandom);
            n    = int'($urandom_range(0, 4));
            model_instr(kind, wr, br, n, -1, 0);
            exec_instr(kind, wr, br, n, -1, 0);
        end
        foreach (obs_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL b2b c%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_halt();
        snap_t s;
        obs_q.delete(); exp_q.delete();
        model_instr(K_HALT, 1'b0, 1'b0, 0, -1, 6);
        exec_instr(K_HALT, 1'b0, 1'b0, 0, -1, 6);
        foreach (obs_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL halt c%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        reset_core();
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            rst = 1'b0; run = 1'b0; dm_ack = 1'($urandom);
            sample(s);
            n_cmp++;
            if (s !== snap_t'('0)) begin
                n_fail++;
                $display("FAIL halt_rst k%0d got=%h exp=%h", k, s, snap_t'('0));
            end
        end
    endtask

    task automatic test_rst_mid_mem();
        snap_t s;
        start_core();
        obs_q.delete(); exp_q.delete();
        model_instr(K_LOAD, 1'b1, 1'b0, 5, 4, 0);
        exec_instr(K_LOAD, 1'b1, 1'b0, 5, 4, 0);
        foreach (obs_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rstmem c%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            rst = 1'b0; run = 1'b0; dm_ack = 1'b1;
            sample(s);
            n_cmp++;
            if (s !== snap_t'('0)) begin
                n_fail++;
                $display("FAIL rstmem_idle k%0d got=%h exp=%h", k, s, snap_t'('0));
            end
        end
    endtask

    task automatic test_saturation();
        snap_t s;
        reset_core();
        start_core();
        obs_q.delete(); exp_q.delete();
        for (int k = 0; k < 20; k++) begin
            model_instr(K_ALU, 1'b1, 1'b0, 0, -1, 0);
            exec_instr(K_ALU, 1'b1, 1'b0, 0, -1, 0);
        end
        foreach (obs_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL sat c%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        next_cycle();
        is_load = 1'b0; is_store = 1'b0; is_halt = 1'b0;
        sample(s);
        n_cmp++;
        if (cycle_cnt4 !== 4'd15 || instret4 !== 4'd15 || instret !== 32'd20 || cycle_cnt !== 32'd80) begin
            n_fail++;
            $display("FAIL sat_final got cyc4=%0d ret4=%0d ret=%0d cyc=%0d exp 15 15 20 80",
                     cycle_cnt4, instret4, instret, cycle_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_load();
        test_store();
        test_back_to_back();
        test_halt();
        test_rst_mid_mem();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
